// File: rtl/gate_pkg.sv
// gate_pkg: op encoding and bitwise result function shared by the gate ALU pipe
package gate_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;
  // Computed at full 64-bit width; callers truncate to their operand width.
  function automatic logic [63:0] gate_calc(op_e op, logic [63:0] a, logic [63:0] b);
    return op == OP_AND  ? a & b :
           op == OP_OR   ? a | b :
           op == OP_XOR  ? a ^ b :
           op == OP_NAND ? ~(a & b) :
           op == OP_NOR  ? ~(a | b) :
           op == OP_XNOR ? ~(a ^ b) :
           op == OP_NOTA ? ~a : a;
  endfunction
endpackage

// File: rtl/gate_skid_fifo.sv
// gate_skid_fifo: 2-entry order-preserving FIFO; caller qualifies push/pop against occupancy
module gate_skid_fifo #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic [1:0]    o_occ
);
  logic [DW-1:0] r_mem [2];
  logic          r_wr;
  logic          r_rd;
  logic [1:0]    r_occ;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_occ <= r_occ + 2'(i_push) - 2'(i_pop);
    end
  end
  assign o_dout = r_mem[r_rd];
  assign o_occ  = r_occ;
endmodule

// File: rtl/gate_alu_pipe.sv
// gate_alu_pipe: bitwise gate ALU feeding a 2-entry result queue with a handshake counter
module gate_alu_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] txn_count
);
  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_dout;
  logic [1:0]       w_occ;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] r_txn;
  assign w_res     = WIDTH'(gate_calc(op_e'(op), 64'(a), 64'(b)));
  assign in_ready  = w_occ < 2'd2;
  assign out_valid = w_occ != 2'd0;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  gate_skid_fifo #(.DW(WIDTH + 1)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_din  ({w_res == '0, w_res}),
    .i_pop  (w_pop),
    .o_dout (w_dout),
    .o_occ  (w_occ)
  );
  assign y      = w_dout[WIDTH-1:0];
  assign y_zero = w_dout[WIDTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_txn <= '0;
    else if (w_pop) r_txn <= r_txn + CNT_W'(1);
  end
  assign txn_count = r_txn;
endmodule

// File: tb/tb_gate_alu_pipe.sv
// tb_gate_alu_pipe: directed vectors with hand-computed results for gate_alu_pipe
module tb_gate_alu_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  op = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  y;
  logic        y_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] txn_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  sweep_exp [8] = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hC3};

  gate_alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .y_zero    (y_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top);
    a = ta;
    b = tb;
    op = top;
    in_valid = 1'b1;
  endtask

  initial begin
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_y", 64'(y), 64'd0);
    check("rst_y_zero", 64'(y_zero), 64'd0);
    check("rst_txn", 64'(txn_count), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // truth sweep with one push and one pop per cycle once primed
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'hC3, 8'hA5, 3'(i));
      tick();
      check($sformatf("sweep_y_op%0d", i), 64'(y), 64'(sweep_exp[i]));
      check($sformatf("sweep_zero_op%0d", i), 64'(y_zero), 64'd0);
      check($sformatf("sweep_valid_op%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("sweep_ready_op%0d", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("sweep_drained", 64'(out_valid), 64'd0);
    check("sweep_txn", 64'(txn_count), 64'd8);

    out_ready = 1'b0;
    send(8'h0F, 8'hF0, 3'd0);
    tick();
    in_valid = 1'b0;
    check("zero_y", 64'(y), 64'h00);
    check("zero_flag", 64'(y_zero), 64'd1);
    check("zero_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("zero_popped", 64'(out_valid), 64'd0);
    check("zero_txn", 64'(txn_count), 64'd9);

    out_ready = 1'b0;
    send(8'h11, 8'h00, 3'd7);
    tick();
    check("bp_ready1", 64'(in_ready), 64'd1);
    check("bp_head1", 64'(y), 64'h11);
    send(8'h22, 8'h00, 3'd7);
    tick();
    check("bp_ready2", 64'(in_ready), 64'd0);
    check("bp_head2", 64'(y), 64'h11);
    send(8'h33, 8'h00, 3'd7);
    tick();
    check("bp_ready3", 64'(in_ready), 64'd0);
    check("bp_hold", 64'(y), 64'h11);
    check("bp_txn_hold", 64'(txn_count), 64'd9);
    out_ready = 1'b1;
    tick();
    check("bp_pop1", 64'(y), 64'h22);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_pop2", 64'(y), 64'h33);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_txn", 64'(txn_count), 64'd12);

    out_ready = 1'b0;
    send(8'h44, 8'h00, 3'd7);
    tick();
    out_ready = 1'b1;
    send(8'h55, 8'h00, 3'd7);
    tick();
    in_valid = 1'b0;
    check("pp_head", 64'(y), 64'h55);
    check("pp_valid", 64'(out_valid), 64'd1);
    check("pp_ready", 64'(in_ready), 64'd1);
    tick();
    check("pp_single", 64'(out_valid), 64'd0);
    check("pp_txn", 64'(txn_count), 64'd14);

    out_ready = 1'b0;
    send(8'h66, 8'h00, 3'd7);
    tick();
    send(8'h77, 8'h00, 3'd7);
    tick();
    in_valid = 1'b0;
    check("rm_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_valid", 64'(out_valid), 64'd0);
    check("rm_ready", 64'(in_ready), 64'd1);
    check("rm_txn", 64'(txn_count), 64'd0);
    check("rm_y", 64'(y), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rm_discarded", 64'(out_valid), 64'd0);

    // first edge only pushes, so 65537 edges give 65536 pops
    send(8'h5A, 8'h00, 3'd7);
    repeat (65537) @(posedge clk);
    #1;
    check("wrap_zero", 64'(txn_count), 64'd0);
    tick();
    check("wrap_one", 64'(txn_count), 64'd1);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
